// File: rtl/beta_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request per fetch grant
// and holds the fetched word until the decode side acknowledges it.
module beta_fetch_stage #(
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          AddrWidth = 32,
   parameter logic [AddrWidth-1:0] BootAddr  = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ifs_fetch_en_i,
   output logic                 ifs_busy_o,
   input  logic                 ifs_redirect_i,
   input  logic [AddrWidth-1:0] ifs_redirect_pc_i,
   output logic                 imem_req_o,
   output logic [AddrWidth-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [DataWidth-1:0] imem_rdata_i,
   input  logic                 imem_err_i,
   output logic                 ifs_valid_o,
   output logic [DataWidth-1:0] ifs_instr_o,
   output logic [AddrWidth-1:0] ifs_pc_o,
   output logic                 ifs_fault_o,
   input  logic                 ifs_instr_ack_i
);

   localparam logic [DataWidth-1:0] NopInstr = DataWidth'(32'h0000_0013);
   localparam logic [AddrWidth-1:0] PcStep   = AddrWidth'(4);
   localparam logic [AddrWidth-1:0] AlignMsk = ~AddrWidth'(3);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FLUSH = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   pc_q, pc_d;
   logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
   logic                   drop_q, drop_d;
   logic [DataWidth-1:0]   instr_q, instr_d;
   logic [AddrWidth-1:0]   out_pc_q, out_pc_d;
   logic                   fault_q, fault_d;
   logic                   req_q, busy_q, valid_q;
   logic [AddrWidth-1:0]   target;

   assign target = ifs_redirect_pc_i & AlignMsk;

   // State and datapath registers; status outputs are registered from the next state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         pc_q       <= BootAddr;
         req_addr_q <= BootAddr;
         drop_q     <= 1'b0;
         instr_q    <= NopInstr;
         out_pc_q   <= BootAddr;
         fault_q    <= 1'b0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
         instr_q    <= instr_d;
         out_pc_q   <= out_pc_d;
         fault_q    <= fault_d;
         req_q      <= (state_d == REQ);
         busy_q     <= (state_d == REQ) || (state_d == WAIT) || (state_d == FLUSH);
         valid_q    <= (state_d == HOLD);
      end
   end

   // Next-state and datapath update; a redirect always retargets the PC
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      drop_d     = drop_q;
      instr_d    = instr_q;
      out_pc_d   = out_pc_q;
      fault_d    = fault_q;

      unique case (state_q)
         IDLE: begin
            if (ifs_redirect_i) begin
               pc_d = target;
            end else if (ifs_fetch_en_i) begin
               req_addr_d = pc_q;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (imem_gnt_i) begin
               drop_d = 1'b0;
               if (drop_q || ifs_redirect_i) begin
                  state_d = FLUSH;
                  if (ifs_redirect_i) pc_d = target;
               end else begin
                  pc_d    = pc_q + PcStep;
                  state_d = WAIT;
               end
            end else if (ifs_redirect_i) begin
               pc_d   = target;
               drop_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (ifs_redirect_i) begin
                  pc_d    = target;
                  state_d = IDLE;
               end else begin
                  instr_d  = imem_rdata_i;
                  out_pc_d = req_addr_q;
                  fault_d  = imem_err_i;
                  state_d  = HOLD;
               end
            end else if (ifs_redirect_i) begin
               pc_d    = target;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (ifs_redirect_i) pc_d = target;
            if (imem_rvalid_i) state_d = IDLE;
         end
         HOLD: begin
            if (ifs_redirect_i) begin
               pc_d    = target;
               state_d = IDLE;
            end else if (ifs_instr_ack_i) begin
               if (ifs_fetch_en_i) begin
                  req_addr_d = pc_q;
                  state_d    = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = req_addr_q;
   assign ifs_busy_o  = busy_q;
   assign ifs_valid_o = valid_q;
   assign ifs_instr_o = instr_q;
   assign ifs_pc_o    = out_pc_q;
   assign ifs_fault_o = fault_q;

endmodule

// File: tb/tb_beta_fetch_stage.sv
// Randomized bench for beta_fetch_stage: a memory responder plus a
// transaction-level model of the PC, the outstanding fetch and the held word.
module tb_beta_fetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ifs_fetch_en_i;
   logic        ifs_busy_o;
   logic        ifs_redirect_i;
   logic [31:0] ifs_redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        imem_err_i;
   logic        ifs_valid_o;
   logic [31:0] ifs_instr_o;
   logic [31:0] ifs_pc_o;
   logic        ifs_fault_o;
   logic        ifs_instr_ack_i;

   int n_checks = 0;
   int n_errors = 0;
   int n_pres   = 0;

   always #5 clk_i = ~clk_i;

   beta_fetch_stage #(
      .DataWidth(32),
      .AddrWidth(32),
      .BootAddr (32'h0000_0000)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ifs_fetch_en_i   (ifs_fetch_en_i),
      .ifs_busy_o       (ifs_busy_o),
      .ifs_redirect_i   (ifs_redirect_i),
      .ifs_redirect_pc_i(ifs_redirect_pc_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .imem_err_i       (imem_err_i),
      .ifs_valid_o      (ifs_valid_o),
      .ifs_instr_o      (ifs_instr_o),
      .ifs_pc_o         (ifs_pc_o),
      .ifs_fault_o      (ifs_fault_o),
      .ifs_instr_ack_i  (ifs_instr_ack_i)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // Reference model: next fetch PC, one outstanding fetch, one held word
   logic        m_busy, m_granted, m_squash, m_hold;
   logic [31:0] m_pc, m_req_addr, m_instr, m_opc;
   logic        m_fault;

   // Memory responder
   logic        mem_pending;
   int          mem_delay;
   logic [31:0] mem_addr, gnt_addr;
   logic        stale_ok = 1'b0;

   int p_fe = 80, p_redir = 8, p_ack = 50, p_gnt = 60, max_delay = 3;

   task automatic model_reset();
      m_busy = 0; m_granted = 0; m_squash = 0; m_hold = 0;
      m_pc = 32'h0; m_req_addr = 32'h0; m_opc = 32'h0;
      m_instr = 32'h0000_0013; m_fault = 0;
   endtask

   task automatic model_start();
      m_busy = 1; m_granted = 0; m_squash = 0; m_req_addr = m_pc;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      tgt = ifs_redirect_pc_i & 32'hFFFF_FFFC;
      if (m_busy && !m_granted) begin
         if (ifs_redirect_i) m_squash = 1;
         if (imem_gnt_i) begin
            m_granted = 1;
            if (!m_squash) m_pc = m_pc + 32'd4;
         end
         if (ifs_redirect_i) m_pc = tgt;
      end else if (m_busy) begin
         if (imem_rvalid_i) begin
            m_busy = 0;
            if (!m_squash && !ifs_redirect_i) begin
               m_hold = 1; m_instr = mem_word(m_req_addr); m_opc = m_req_addr;
               m_fault = imem_err_i; n_pres++;
            end
         end else if (ifs_redirect_i) begin
            m_squash = 1;
         end
         if (ifs_redirect_i) m_pc = tgt;
      end else if (m_hold) begin
         if (ifs_redirect_i) begin
            m_hold = 0; m_pc = tgt;
         end else if (ifs_instr_ack_i) begin
            m_hold = 0;
            if (ifs_fetch_en_i) model_start();
         end
      end else begin
         if (ifs_redirect_i) m_pc = tgt;
         else if (ifs_fetch_en_i) model_start();
      end
   endtask

   task automatic check_outputs();
      check("req",   imem_req_o,  m_busy && !m_granted);
      check("addr",  imem_addr_o, m_req_addr);
      check("busy",  ifs_busy_o,  m_busy);
      check("valid", ifs_valid_o, m_hold);
      check("instr", ifs_instr_o, m_instr);
      check("pc",    ifs_pc_o,    m_opc);
      check("fault", ifs_fault_o, m_fault);
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(4))
         0:       return 32'hFFFF_FFFC;
         1:       return 32'hFFFF_FFFD;
         2:       return 32'h0000_0203;
         3:       return 32'h0000_0080;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_cycle();
      ifs_fetch_en_i    = ($urandom_range(99) < p_fe);
      ifs_redirect_i    = ($urandom_range(99) < p_redir);
      ifs_redirect_pc_i = pick_target();
      ifs_instr_ack_i   = ($urandom_range(99) < p_ack);
      imem_gnt_i        = imem_req_o && !mem_pending && ($urandom_range(99) < p_gnt);
      gnt_addr          = imem_addr_o;
      imem_rvalid_i     = mem_pending && (mem_delay == 0);
      imem_rdata_i      = imem_rvalid_i ? mem_word(mem_addr) : $urandom;
      imem_err_i        = ($urandom_range(3) == 0);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         check_outputs();
         drive_cycle();
         @(posedge clk_i);
         model_step();
         if (imem_rvalid_i) mem_pending = 0;
         else if (mem_pending) mem_delay--;
         if (imem_gnt_i) begin
            mem_pending = 1;
            mem_delay   = $urandom_range(max_delay);
            mem_addr    = gnt_addr;
         end
      end
   endtask

   always @(posedge clk_i) begin
      if (!rst_i && imem_rvalid_i && !stale_ok)
         assert (ifs_busy_o && !imem_req_o)
         else $error("rvalid outside an outstanding fetch");
   end

   initial begin
      int bound;
      rst_i = 1; ifs_fetch_en_i = 0; ifs_redirect_i = 0; ifs_redirect_pc_i = 0;
      imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; imem_err_i = 0;
      ifs_instr_ack_i = 0; mem_pending = 0; mem_delay = 0; mem_addr = 0; gnt_addr = 0;
      model_reset();
      #1 check_outputs();
      @(negedge clk_i);
      @(negedge clk_i) rst_i = 0;

      // Zero-wait streaming with fetch always granted and every word acked
      p_fe = 100; p_redir = 0; p_ack = 100; p_gnt = 100; max_delay = 0;
      run_cycles(20);

      // Random mix with memory stalls and redirects
      p_fe = 80; p_redir = 8; p_ack = 50; p_gnt = 60; max_delay = 3;
      run_cycles(1500);

      // Reset in the middle of a granted fetch; the late response must be ignored
      bound = 0;
      while (!(m_busy && m_granted) && bound < 200) begin
         run_cycles(1);
         bound++;
      end
      check("mid_reset_reached", (m_busy && m_granted), 1'b1);
      @(negedge clk_i);
      ifs_fetch_en_i = 0; ifs_redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
      rst_i = 1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk_i);
      rst_i = 0; stale_ok = 1;
      imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; imem_err_i = 1;
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      check_outputs();
      imem_rvalid_i = 0; imem_err_i = 0; stale_ok = 0; mem_pending = 0;

      // Redirect-heavy random phase
      p_redir = 20; p_ack = 40; p_gnt = 50;
      run_cycles(1500);

      check("words_presented", (n_pres > 20), 1'b1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
